// File: rtl/uart_rx.sv
// Serial receiver for start/data/stop framing (LSB first) with a two-flop input
// synchroniser, mid-bit sampling and registered single-cycle result pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end

            // Re-check the start bit half a bit later; a high line means a glitch.
            ST_START: begin
                if (clk_cnt_q == CNT_MID) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    clk_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d   = ST_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            // Leaving at mid-stop gives half a bit of slack for back-to-back frames.
            ST_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven serially, expected pulses are queued
// with their due cycle and compared by a monitor when the DUT pulses.
module tb_uart_rx;

    localparam int CPB        = 16;
    localparam int DB         = 8;
    localparam int HALF       = CPB / 2;
    localparam int SYNC_LAT   = 2;
    localparam int PULSE_LAT  = HALF + (DB + 1) * CPB + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         rise_cyc = -1;
    int         fall_cyc = -1;
    logic [7:0] last_good = 8'h00;
    exp_t       sb[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit jit_en,
                              output int t0);
        int   jit[11] = '{0, 3, -3, 2, -3, 3, -2, 1, -3, 3, 0};
        exp_t e;
        rx = 1'b0;
        t0 = cyc + SYNC_LAT;
        e.is_err = !stop;
        e.data   = stop ? d : last_good;
        e.cyc    = t0 + PULSE_LAT;
        sb.push_back(e);
        if (stop) last_good = d;
        for (int k = 0; k < 10; k++) begin
            rx = (k == 0) ? 1'b0 : (k == 9) ? stop : d[k-1];
            idle(jit_en ? CPB + jit[k+1] - jit[k] : CPB);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) idle(1);
        check(tag, sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every pulse and tracks busy edges.
    initial begin
        exp_t e;
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) rise_cyc = cyc;
            if (!busy && busy_prev) fall_cyc = cyc;
            busy_prev = busy;
            if (data_valid || frame_err) begin
                check("pulse_exclusive", {31'd0, data_valid & frame_err}, 0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, data_valid, frame_err}, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    check("pulse_data", {24'd0, data_out}, {24'd0, e.data});
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t0_b;

        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        check("reset_data_out", {24'd0, data_out}, 0);
        check("reset_data_valid", {31'd0, data_valid}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        idle(10);

        // 1: single good frame, exact pulse cycle and busy window
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        idle(4);
        drain("t1_drain");
        check("t1_busy_rise", rise_cyc, t0 + 1);
        check("t1_busy_fall", fall_cyc, t0 + PULSE_LAT);
        check("t1_data_out", {24'd0, data_out}, 32'hA5);
        idle(10);

        // 2: short low glitch rejected at mid-start
        rx = 1'b0;
        t0 = cyc + SYNC_LAT;
        idle(4);
        rx = 1'b1;
        idle(20);
        check("t2_busy_rise", rise_cyc, t0 + 1);
        check("t2_busy_fall", fall_cyc, t0 + HALF + 1);
        check("t2_data_out", {24'd0, data_out}, {24'd0, last_good});
        check("t2_no_pulse", sb.size(), 0);

        // 3: bad stop bit, line held low, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        rx = 1'b0;
        idle(32);
        check("t3_break_busy", {31'd0, busy}, 1);
        idle(32);
        check("t3_break_busy_late", {31'd0, busy}, 1);
        check("t3_data_held", {24'd0, data_out}, 32'hA5);
        rx = 1'b1;
        idle(8);
        check("t3_break_exit", {31'd0, busy}, 0);
        idle(8);
        send_frame(8'h01, 1'b1, 1'b0, t0);
        idle(4);
        drain("t3_drain");
        check("t3_data_out", {24'd0, data_out}, 32'h01);
        idle(10);

        // 4: back-to-back frames, no idle bits
        send_frame(8'h00, 1'b1, 1'b0, t0);
        send_frame(8'hFF, 1'b1, 1'b0, t0_b);
        idle(4);
        drain("t4_drain");
        check("t4_data_out", {24'd0, data_out}, 32'hFF);
        idle(10);

        // 5: reset after four data bits of 0x5A, then a clean frame
        rx = 1'b0;
        idle(CPB);
        for (int k = 0; k < 4; k++) begin
            rx = 8'h5A >> k;
            idle(CPB);
        end
        rst = 1'b1;
        idle(3);
        check("t5_rst_data_out", {24'd0, data_out}, 0);
        check("t5_rst_valid", {31'd0, data_valid}, 0);
        check("t5_rst_ferr", {31'd0, frame_err}, 0);
        check("t5_rst_busy", {31'd0, busy}, 0);
        rx = 1'b1;
        idle(2);
        rst = 1'b0;
        last_good = 8'h00;
        idle(20);
        check("t5_no_partial", {24'd0, data_out}, 0);
        send_frame(8'hC3, 1'b1, 1'b0, t0);
        idle(4);
        drain("t5_drain");
        check("t5_data_out", {24'd0, data_out}, 32'hC3);
        idle(10);

        // 6: jittered bit edges
        send_frame(8'h81, 1'b1, 1'b1, t0);
        idle(4);
        drain("t6_drain");
        check("t6_data_out", {24'd0, data_out}, 32'h81);
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
